// File: rtl/vdp_spinfo_pkg.sv
// Shared definitions for the double-banked sprite-info line buffer:
// default geometry, count-width helper and the sprite-info field layout.
package vdp_spinfo_pkg;

    localparam int SPI_DEPTH = 8;
    localparam int SPI_WIDTH = 32;

    // Field layout inside one entry, LSB first: X, pattern, color, CC, IC.
    localparam int SPI_X_LSB   = 0;
    localparam int SPI_X_W     = 9;
    localparam int SPI_PAT_LSB = SPI_X_LSB + SPI_X_W;
    localparam int SPI_PAT_W   = 16;
    localparam int SPI_COL_LSB = SPI_PAT_LSB + SPI_PAT_W;
    localparam int SPI_COL_W   = 4;
    localparam int SPI_CC_BIT  = SPI_COL_LSB + SPI_COL_W;
    localparam int SPI_IC_BIT  = SPI_CC_BIT + 1;

    // Width of a counter that must hold 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic logic [SPI_WIDTH-1:0] spinfo_pack(
        input logic [SPI_X_W-1:0]   x,
        input logic [SPI_PAT_W-1:0] pattern,
        input logic [SPI_COL_W-1:0] color,
        input logic                 cc,
        input logic                 ic
    );
        logic [SPI_WIDTH-1:0] r_word;
        r_word                             = '0;
        r_word[SPI_X_LSB   +: SPI_X_W]     = x;
        r_word[SPI_PAT_LSB +: SPI_PAT_W]   = pattern;
        r_word[SPI_COL_LSB +: SPI_COL_W]   = color;
        r_word[SPI_CC_BIT]                 = cc;
        r_word[SPI_IC_BIT]                 = ic;
        return r_word;
    endfunction

endpackage

// File: rtl/vdp_spinfo_buf_if.sv
// Fill/display bus of the sprite-info line buffer; the master is the
// sprite evaluator plus the line renderer, the slave is the buffer.
interface vdp_spinfo_buf_if import vdp_spinfo_pkg::*; #(
    parameter int DEPTH = SPI_DEPTH,
    parameter int WIDTH = SPI_WIDTH
) ();
    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic             SWAP;
    logic             WR_EN;
    logic [WIDTH-1:0] WR_DATA;
    logic [CW-1:0]    WR_COUNT;
    logic             FULL;
    logic             OVERFLOW;
    logic [AW-1:0]    RD_ADDR;
    logic [WIDTH-1:0] RD_DATA;
    logic             RD_VALID;
    logic [CW-1:0]    RD_COUNT;
    logic             RD_OVF;

    modport master (
        output SWAP, WR_EN, WR_DATA, RD_ADDR,
        input  WR_COUNT, FULL, OVERFLOW, RD_DATA, RD_VALID, RD_COUNT, RD_OVF
    );

    modport slave (
        input  SWAP, WR_EN, WR_DATA, RD_ADDR,
        output WR_COUNT, FULL, OVERFLOW, RD_DATA, RD_VALID, RD_COUNT, RD_OVF
    );
endinterface

// File: rtl/vdp_spinfo_bank.sv
// One DEPTH x WIDTH sprite-info bank: single write port, read through a
// registered address so it maps onto block or distributed RAM.
module vdp_spinfo_bank #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_raddr;

    // NOTE: the storage array has no reset on purpose; a reset term would stop
    // RAM inference. Stale words are harmless because the counts mask them.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_raddr <= '0;
        else        r_raddr <= i_raddr;
    end

    assign o_rdata = r_mem[r_raddr];
endmodule

// File: rtl/vdp_spinfo_buf.sv
// Double-banked sprite-info line buffer: the evaluator fills one bank while
// the renderer reads the other; SWAP at the line boundary exchanges them.
module vdp_spinfo_buf import vdp_spinfo_pkg::*; #(
    parameter int DEPTH = SPI_DEPTH,
    parameter int WIDTH = SPI_WIDTH,
    parameter int LIMIT = DEPTH
) (
    input  logic            CLK21M,
    input  logic            RESET_n,
    vdp_spinfo_buf_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic             r_sel;
    logic             r_rd_sel;
    logic [CW-1:0]    r_wr_count;
    logic             r_ovf;
    logic [CW-1:0]    r_rd_count;
    logic             r_rd_ovf;
    logic [AW-1:0]    r_rd_addr;

    logic             w_full;
    logic             w_wr_ok;
    logic [CW-1:0]    w_count_next;
    logic             w_ovf_next;
    logic             w_rd_valid;
    logic [WIDTH-1:0] w_rdata [2];

    assign w_full       = (r_wr_count == CW'(LIMIT));
    assign w_wr_ok      = bus.WR_EN && !w_full;
    assign w_count_next = r_wr_count + CW'(w_wr_ok);
    assign w_ovf_next   = r_ovf | (bus.WR_EN & w_full);

    // Bank b is the fill bank while r_sel == b; only that bank is ever written.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        vdp_spinfo_bank #(
            .DEPTH (DEPTH),
            .WIDTH (WIDTH)
        ) u_bank (
            .clk     (CLK21M),
            .rst_n   (RESET_n),
            .i_we    (w_wr_ok && (r_sel == 1'(b))),
            .i_waddr (r_wr_count[AW-1:0]),
            .i_wdata (bus.WR_DATA),
            .i_raddr (bus.RD_ADDR),
            .o_rdata (w_rdata[b])
        );
    end

    // A write coinciding with SWAP lands in the outgoing bank, so the handed-over
    // count and overflow are taken from the post-write values.
    // NOTE: every register here uses <= so all of them see the pre-edge values.
    always_ff @(posedge CLK21M or negedge RESET_n) begin
        if (!RESET_n) begin
            r_sel      <= 1'b0;
            r_rd_sel   <= 1'b1;
            r_wr_count <= '0;
            r_ovf      <= 1'b0;
            r_rd_count <= '0;
            r_rd_ovf   <= 1'b0;
            r_rd_addr  <= '0;
        end else begin
            r_rd_addr <= bus.RD_ADDR;
            r_rd_sel  <= ~(r_sel ^ bus.SWAP);
            if (bus.SWAP) begin
                r_sel      <= ~r_sel;
                r_rd_count <= w_count_next;
                r_rd_ovf   <= w_ovf_next;
                r_wr_count <= '0;
                r_ovf      <= 1'b0;
            end else begin
                r_wr_count <= w_count_next;
                r_ovf      <= w_ovf_next;
            end
        end
    end

    assign w_rd_valid   = (CW'(r_rd_addr) < r_rd_count);

    assign bus.WR_COUNT = r_wr_count;
    assign bus.FULL     = w_full;
    assign bus.OVERFLOW = r_ovf;
    assign bus.RD_COUNT = r_rd_count;
    assign bus.RD_OVF   = r_rd_ovf;
    assign bus.RD_VALID = w_rd_valid;
    assign bus.RD_DATA  = w_rd_valid ? w_rdata[r_rd_sel] : '0;
endmodule

// File: tb/tb_vdp_spinfo_buf.sv
// Scoreboard bench for vdp_spinfo_buf: two instances (LIMIT=DEPTH and LIMIT=4)
// share one stimulus stream and are compared against a queue-level line model.
module tb_vdp_spinfo_buf;
    import vdp_spinfo_pkg::*;

    localparam int DEPTH   = SPI_DEPTH;
    localparam int WIDTH   = SPI_WIDTH;
    localparam int AW      = $clog2(DEPTH);
    localparam int CW      = count_width(DEPTH);
    localparam int LIMIT_B = 4;

    typedef struct {
        logic [CW-1:0]    wr_count;
        logic             full;
        logic             ovf;
        logic [CW-1:0]    rd_count;
        logic             rd_ovf;
        logic             rd_valid;
        logic [WIDTH-1:0] rd_data;
    } exp_t;

    logic CLK21M  = 1'b0;
    logic RESET_n = 1'b0;
    always #5 CLK21M = ~CLK21M;

    vdp_spinfo_buf_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus_a ();
    vdp_spinfo_buf_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus_b ();

    vdp_spinfo_buf #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut_a (
        .CLK21M  (CLK21M),
        .RESET_n (RESET_n),
        .bus     (bus_a)
    );

    vdp_spinfo_buf #(.DEPTH(DEPTH), .WIDTH(WIDTH), .LIMIT(LIMIT_B)) dut_b (
        .CLK21M  (CLK21M),
        .RESET_n (RESET_n),
        .bus     (bus_b)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    endtask

    // Line model: the fill line is a list of accepted entries, the display line
    // is a snapshot of the previous fill line taken at SWAP.
    logic [WIDTH-1:0] m_fill [2][DEPTH];
    logic [WIDTH-1:0] m_disp [2][DEPTH];
    int               m_fcnt [2];
    int               m_dcnt [2];
    bit               m_fovf [2];
    bit               m_dovf [2];
    exp_t             q0 [$];
    exp_t             q1 [$];

    function automatic int lim_of(input int k);
        return (k == 0) ? DEPTH : LIMIT_B;
    endfunction

    task automatic model_edge(input logic sw, input logic we, input logic [WIDTH-1:0] d,
                              input logic [AW-1:0] ra);
        for (int k = 0; k < 2; k++) begin
            exp_t e;
            if (!RESET_n) begin
                m_fcnt[k] = 0;
                m_dcnt[k] = 0;
                m_fovf[k] = 0;
                m_dovf[k] = 0;
                e.rd_valid = 1'b0;
                e.rd_data  = '0;
            end else begin
                if (we) begin
                    if (m_fcnt[k] < lim_of(k)) begin
                        m_fill[k][m_fcnt[k]] = d;
                        m_fcnt[k]++;
                    end else begin
                        m_fovf[k] = 1;
                    end
                end
                if (sw) begin
                    for (int i = 0; i < DEPTH; i++) m_disp[k][i] = m_fill[k][i];
                    m_dcnt[k] = m_fcnt[k];
                    m_dovf[k] = m_fovf[k];
                    m_fcnt[k] = 0;
                    m_fovf[k] = 0;
                end
                e.rd_valid = (int'(ra) < m_dcnt[k]);
                e.rd_data  = e.rd_valid ? m_disp[k][ra] : '0;
            end
            e.wr_count = CW'(m_fcnt[k]);
            e.full     = (m_fcnt[k] == lim_of(k));
            e.ovf      = m_fovf[k];
            e.rd_count = CW'(m_dcnt[k]);
            e.rd_ovf   = m_dovf[k];
            if (k == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    task automatic drive(input logic sw, input logic we, input logic [WIDTH-1:0] d,
                         input logic [AW-1:0] ra);
        bus_a.SWAP = sw; bus_a.WR_EN = we; bus_a.WR_DATA = d; bus_a.RD_ADDR = ra;
        bus_b.SWAP = sw; bus_b.WR_EN = we; bus_b.WR_DATA = d; bus_b.RD_ADDR = ra;
    endtask

    task automatic step(input logic sw, input logic we, input logic [WIDTH-1:0] d,
                        input logic [AW-1:0] ra);
        drive(sw, we, d, ra);
        @(posedge CLK21M);
        model_edge(sw, we, d, ra);
        #1;
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        return AW'($urandom_range(0, DEPTH - 1));
    endfunction

    task automatic compare(input string tag, input exp_t e,
                           input logic [CW-1:0] wr_count, input logic full, input logic ovf,
                           input logic [CW-1:0] rd_count, input logic rd_ovf,
                           input logic rd_valid, input logic [WIDTH-1:0] rd_data);
        check({tag, ".WR_COUNT"}, WIDTH'(wr_count), WIDTH'(e.wr_count));
        check({tag, ".FULL"},     WIDTH'(full),     WIDTH'(e.full));
        check({tag, ".OVERFLOW"}, WIDTH'(ovf),      WIDTH'(e.ovf));
        check({tag, ".RD_COUNT"}, WIDTH'(rd_count), WIDTH'(e.rd_count));
        check({tag, ".RD_OVF"},   WIDTH'(rd_ovf),   WIDTH'(e.rd_ovf));
        check({tag, ".RD_VALID"}, WIDTH'(rd_valid), WIDTH'(e.rd_valid));
        check({tag, ".RD_DATA"},  rd_data,          e.rd_data);
    endtask

    exp_t mon_e;
    always @(negedge CLK21M) begin
        if (q0.size() > 0) begin
            mon_e = q0.pop_front();
            compare("a", mon_e, bus_a.WR_COUNT, bus_a.FULL, bus_a.OVERFLOW, bus_a.RD_COUNT,
                    bus_a.RD_OVF, bus_a.RD_VALID, bus_a.RD_DATA);
        end
        if (q1.size() > 0) begin
            mon_e = q1.pop_front();
            compare("b", mon_e, bus_b.WR_COUNT, bus_b.FULL, bus_b.OVERFLOW, bus_b.RD_COUNT,
                    bus_b.RD_OVF, bus_b.RD_VALID, bus_b.RD_DATA);
        end
    end

    initial begin
        logic [WIDTH-1:0] ent_a, ent_b, ent_c, ent_d;
        ent_a = spinfo_pack(9'h011, 16'hA5A5, 4'h1, 1'b0, 1'b1);
        ent_b = spinfo_pack(9'h1F0, 16'h5A5A, 4'h7, 1'b1, 1'b0);
        ent_c = spinfo_pack(9'h0C3, 16'h1234, 4'hE, 1'b1, 1'b1);
        ent_d = spinfo_pack(9'h155, 16'hBEEF, 4'h9, 1'b0, 1'b0);

        // Reset with write/swap requests pending.
        step(1'b1, 1'b1, ent_a, 3'd2);
        step(1'b0, 1'b0, '0, 3'd0);
        RESET_n = 1'b1;

        // A, B, C then SWAP; read entry 1 then out-of-range entry 3.
        step(1'b0, 1'b1, ent_a, 3'd0);
        step(1'b0, 1'b1, ent_b, 3'd0);
        step(1'b0, 1'b1, ent_c, 3'd0);
        step(1'b1, 1'b0, '0, 3'd1);
        step(1'b0, 1'b0, '0, 3'd1);
        step(1'b0, 1'b0, '0, 3'd3);

        // Six writes: instance b saturates at 4 and flags overflow.
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, $urandom, rnd_addr());
        step(1'b1, 1'b0, '0, rnd_addr());
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, '0, AW'(i));

        // Write coinciding with SWAP goes into the outgoing line.
        step(1'b0, 1'b1, $urandom, 3'd0);
        step(1'b0, 1'b1, $urandom, 3'd0);
        step(1'b1, 1'b1, ent_d, 3'd0);
        step(1'b0, 1'b0, '0, 3'd2);

        // Full line of writes while reading the display line continuously.
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b1, $urandom, rnd_addr());
        step(1'b1, 1'b0, '0, rnd_addr());
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, $urandom, AW'(i));

        // Asynchronous reset in the middle of a write.
        step(1'b1, 1'b1, $urandom, 3'd0);
        step(1'b0, 1'b1, $urandom, 3'd0);
        drive(1'b0, 1'b1, $urandom, 3'd0);
        @(negedge CLK21M);
        #1;
        RESET_n = 1'b0;
        #1;
        check("async_rst a.WR_COUNT", WIDTH'(bus_a.WR_COUNT), '0);
        check("async_rst a.FULL",     WIDTH'(bus_a.FULL),     '0);
        check("async_rst a.OVERFLOW", WIDTH'(bus_a.OVERFLOW), '0);
        check("async_rst a.RD_COUNT", WIDTH'(bus_a.RD_COUNT), '0);
        check("async_rst a.RD_OVF",   WIDTH'(bus_a.RD_OVF),   '0);
        check("async_rst a.RD_VALID", WIDTH'(bus_a.RD_VALID), '0);
        check("async_rst a.RD_DATA",  bus_a.RD_DATA,          '0);
        check("async_rst b.WR_COUNT", WIDTH'(bus_b.WR_COUNT), '0);
        check("async_rst b.OVERFLOW", WIDTH'(bus_b.OVERFLOW), '0);
        check("async_rst b.RD_COUNT", WIDTH'(bus_b.RD_COUNT), '0);
        check("async_rst b.RD_VALID", WIDTH'(bus_b.RD_VALID), '0);
        step(1'b1, 1'b1, $urandom, 3'd1);
        RESET_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, '0, AW'(i));

        // Three consecutive lines with 1, 0 and 2 entries.
        step(1'b0, 1'b1, $urandom, rnd_addr());
        step(1'b1, 1'b0, '0, 3'd0);
        step(1'b1, 1'b0, '0, 3'd0);
        step(1'b0, 1'b1, $urandom, 3'd0);
        step(1'b0, 1'b1, $urandom, 3'd0);
        step(1'b1, 1'b0, '0, 3'd0);
        step(1'b0, 1'b0, '0, 3'd1);
        step(1'b0, 1'b0, '0, 3'd2);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), $urandom, rnd_addr());

        drive(1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge CLK21M);
        #1;
        check("scoreboard_drain", WIDTH'(q0.size() + q1.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/vdp_spinfo_buf.md
VDP_SPINFO_BUF -- requirements
Module: vdp_spinfo_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 8, entries per bank (power of two, 4..32).
REQ-002 SHALL have parameter WIDTH, default 32, bits per sprite-info entry.
REQ-003 SHALL have parameter LIMIT, default DEPTH, maximum accepted entries per line (1..DEPTH).
REQ-004 SHALL have port CLK21M  input  1  sole clock; all state on its rising edge.
REQ-005 SHALL have port RESET_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port SWAP  input  1  line boundary; exchanges fill and display banks.
REQ-007 SHALL have port WR_EN  input  1  append WR_DATA to fill bank.
REQ-008 SHALL have port WR_DATA  input  WIDTH  sprite-info entry.
REQ-009 SHALL have port WR_COUNT  output  clog2(DEPTH+1)  entries held in fill bank.
REQ-010 SHALL have port FULL  output  1  WR_COUNT == LIMIT.
REQ-011 SHALL have port OVERFLOW  output  1  sticky; write attempted while FULL since last SWAP.
REQ-012 SHALL have port RD_ADDR  input  clog2(DEPTH)  display-bank entry index.
REQ-013 SHALL have port RD_DATA  output  WIDTH  entry at registered address; zero when invalid.
REQ-014 SHALL have port RD_VALID  output  1  registered RD_ADDR < RD_COUNT.
REQ-015 SHALL have port RD_COUNT  output  clog2(DEPTH+1)  entries in display bank.
REQ-016 SHALL have port RD_OVF  output  1  OVERFLOW value captured at last SWAP.

Function
REQ-017 SHALL hold two banks of DEPTH x WIDTH; a bank-select bit names the fill bank, the other is display.
REQ-018 SHALL, on WR_EN with FULL=0, write WR_DATA to fill bank at index WR_COUNT and increment WR_COUNT next edge.
REQ-019 SHALL, on WR_EN with FULL=1, discard the data, leave WR_COUNT unchanged, and set OVERFLOW next edge.
REQ-020 SHALL, on SWAP, next edge: toggle bank select, RD_COUNT <= post-write fill count, RD_OVF <= post-write overflow, WR_COUNT <= 0, OVERFLOW <= 0.
REQ-021 SHALL, for WR_EN and SWAP in the same cycle, apply the write (or overflow) to the outgoing fill bank first, so it is included in RD_COUNT/RD_OVF.
REQ-022 SHALL register RD_ADDR and the display-bank selector on every edge; RD_DATA/RD_VALID reflect them one cycle later (read latency 1).
REQ-023 SHALL, in the cycle after a SWAP edge, return data from the new display bank for the address sampled at that edge.
REQ-024 SHALL force RD_DATA to all-zeros whenever RD_VALID=0; memory contents are never reset.
REQ-025 SHALL never write the display bank; reads and writes in the same cycle are independent.
REQ-026 SHALL keep WR_COUNT saturated at LIMIT; no wrap-around.

Reset
REQ-027 SHALL, while RESET_n=0: fill bank=0, WR_COUNT=0, FULL=0 (LIMIT>=1), OVERFLOW=0, RD_COUNT=0, RD_OVF=0, registered address=0, RD_VALID=0, RD_DATA=0.
REQ-028 SHALL, on reset assertion mid-line, abandon both banks' logical contents (counts zero) regardless of pending WR_EN/SWAP.
REQ-029 SHALL ignore WR_EN and SWAP in the first edge after RESET_n rises only insofar as normal rules apply; no extra wait states.

Structure
REQ-030 SHALL place DEPTH/WIDTH defaults, the count-width function and the sprite-info field offsets (X 9b, pattern 16b, color 4b, CC 1b, IC 1b) in shared package vdp_spinfo_pkg.
REQ-031 SHALL instantiate one sub-module vdp_spinfo_bank (single-port-write, registered-address read, DEPTH x WIDTH) twice.
REQ-032 SHALL infer block or distributed RAM for banks; no reset on memory arrays.

Verification
REQ-033 SHALL cover: reset, write 3 entries A,B,C, SWAP -> RD_COUNT=3, RD_ADDR=1 gives RD_DATA=B, RD_VALID=1 one cycle later; RD_ADDR=3 -> RD_DATA=0, RD_VALID=0.
REQ-034 SHALL cover: LIMIT=4, 6 writes -> FULL=1 after 4th, WR_COUNT=4, OVERFLOW=1 after 5th; SWAP -> RD_COUNT=4, RD_OVF=1, OVERFLOW=0.
REQ-035 SHALL cover: WR_EN with data D and SWAP in same cycle after 2 writes -> RD_COUNT=3, entry 2 = D, WR_COUNT=0.
REQ-036 SHALL cover: continuous reads of display bank while writing fill bank for a full line -> display data unchanged.
REQ-037 SHALL cover: RESET_n pulsed low asynchronously mid-write -> all outputs zero immediately, RD_VALID=0 after release until next SWAP with entries.
REQ-038 SHALL cover: three consecutive SWAPs with 1, 0, 2 writes -> RD_COUNT sequence 1, 0, 2 and banks alternate correctly.
